mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
//  - Resolves branch and jump redirects.
//  - Performs data-memory accesses over a variable-latency req/ack bus and stalls upstream until ack.
//  - Registers write-back controls and data for the WB stage.
//  - Timeout watchdog aborts a hung access and sets a sticky error flag.
// PARAMETERS
//  TIMEOUT  16       max cycles in BUSY before abort (>=2)
//  CNT_W    5        watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
//  OP_BNE   6'h05    opcode where branch is taken on ~zero; all other Branch ops take on zero
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  in_RegWrite,in_Branch,in_MemtoReg,in_MemRead,in_MemWrite,in_Jump  in 1 each  EX/MEM controls
//  in_opcode    in   6   EX/MEM opcode
//  in_zero      in   1   ALU zero flag
//  in_mux       in   5   destination register
//  in_pc        in   32  branch target
//  inpc         in   32  PC+4, the link value
//  in_alu_out   in   32  ALU result, also the memory address
//  in_rd2       in   32  store data
//  in_jump_addr in   32  jump target
//  mem_req      out  1   memory request
//  mem_we       out  1   1=write, 0=read
//  mem_addr     out  32  address
//  mem_wdata    out  32  write data
//  mem_ack      in   1   one-cycle completion pulse
//  mem_rdata    in   32  read data; valid with mem_ack
//  stall        out  1   hold EX/MEM and all earlier stages
//  redirect     out  1   take next_pc, flush IF/ID/EX
//  next_pc      out  32  redirect target
//  mem_err      out  1   sticky timeout flag
//  wb_RegWrite,wb_MemtoReg  out 1 each  MEM/WB controls
//  wb_alu_out,wb_rdata,wb_pc  out 32 each  MEM/WB data (wb_pc = link PC+4)
//  wb_mux       out  5   MEM/WB destination register
// BEHAVIOUR
//  memop = in_MemRead | in_MemWrite. FSM states: IDLE, BUSY; 2-bit state register.
//  IDLE, memop=0:
//    mem_req=0, stall=0. MEM/WB captures the inputs on the next edge.
//  IDLE, memop=1:
//    mem_req=1, stall=1. Next state BUSY, cnt<=0.
//    MEM/WB loads a bubble: wb_RegWrite=0, wb_MemtoReg=0, data regs hold.
//  BUSY:
//    mem_req=1, stall=~mem_ack, cnt increments each cycle.
//    mem_ack=1: MEM/WB captures the instruction (wb_rdata<=mem_rdata on read, else 0); ->IDLE.
//    no ack and cnt==TIMEOUT-1: stall=0, mem_req stays 1 that cycle, mem_err<=1, MEM/WB bubble; ->IDLE.
//    otherwise: MEM/WB bubble.
//  mem_we=in_MemWrite, mem_addr=in_alu_out, mem_wdata=in_rd2, all combinational.
//    Stable while mem_req=1, because upstream is held.
//  mem_ack while in IDLE: ignored. mem_ack and timeout in the same cycle: ack wins, no error.
//  Minimum memory-op latency is 2 cycles: request, then ack. Non-memory ops take 1 cycle.
//  Redirect, combinational, not gated by stall:
//    taken = in_Branch & (in_opcode==OP_BNE ? ~in_zero : in_zero)
//    redirect = taken | in_Jump
//    next_pc = in_Jump ? in_jump_addr : in_pc. Jump has priority over Branch.
//  Reset (rst=0, any time, including mid-access):
//    state=IDLE, cnt=0, mem_err=0, all wb_* outputs 0.
//    mem_req drops immediately; an in-flight ack after reset is ignored.
//  mem_err clears only on reset.
// TESTING
//  1 ALU op, RegWrite=1, alu_out=0x1234, mux=5 -> next edge wb_RegWrite=1, wb_alu_out=0x1234, wb_mux=5; stall never high.
//  2 Load, addr 0x40, ack 3 cycles after req, rdata=0xDEADBEEF
//      -> stall high 3 cycles, mem_req 4 cycles, one wb capture with wb_rdata=0xDEADBEEF, MemtoReg=1.
//  3 Store, addr 0x80, wdata 0xA5A5A5A5, ack next cycle
//      -> mem_we=1 throughout req; wb_RegWrite=0; stall exactly 1 cycle.
//  4 beq zero=1 -> redirect=1, next_pc=in_pc. bne zero=1 -> redirect=0.
//      Jump plus Branch -> next_pc=in_jump_addr.
//  5 Load with no ack, TIMEOUT=16 -> stall drops after 16 cycles, mem_err=1 and stays, wb_RegWrite=0; next op proceeds normally.
//  6 Assert rst mid-BUSY, then a late ack -> mem_req=0 immediately, wb_* =0, state IDLE, ack ignored.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MEM stage (branch/jump redirect, req/ack data-memory access with
//            timeout watchdog) followed by the MEM/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int          TIMEOUT = 16,
  parameter int          CNT_W   = 5,
  parameter logic [5:0]  OP_BNE  = 6'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_RegWrite,
  input  logic        in_Branch,
  input  logic        in_MemtoReg,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_Jump,
  input  logic [5:0]  in_opcode,
  input  logic        in_zero,
  input  logic [4:0]  in_mux,
  input  logic [31:0] in_pc,
  input  logic [31:0] inpc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rd2,
  input  logic [31:0] in_jump_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] next_pc,
  output logic        mem_err,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_rdata,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_mux
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               wb_regwrite_q, wb_regwrite_d;
  logic               wb_memtoreg_q, wb_memtoreg_d;
  logic [31:0]        wb_alu_out_q, wb_alu_out_d;
  logic [31:0]        wb_rdata_q, wb_rdata_d;
  logic [31:0]        wb_pc_q, wb_pc_d;
  logic [4:0]         wb_mux_q, wb_mux_d;

  logic               memop;
  logic               req;
  logic               timeout_hit;
  logic               taken;

  assign memop       = in_MemRead | in_MemWrite;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign taken    = in_Branch & ((in_opcode == OP_BNE) ? ~in_zero : in_zero);
  assign redirect = taken | in_Jump;
  assign next_pc  = in_Jump ? in_jump_addr : in_pc;

  assign mem_we    = in_MemWrite;
  assign mem_addr  = in_alu_out;
  assign mem_wdata = in_rd2;
  // Qualified by rst so the request vanishes the moment reset asserts.
  assign mem_req   = req & rst;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_err_d     = mem_err_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_alu_out_d  = wb_alu_out_q;
    wb_rdata_d    = wb_rdata_q;
    wb_pc_d       = wb_pc_q;
    wb_mux_d      = wb_mux_q;
    req           = 1'b0;
    stall         = 1'b0;

    case (state_q)
      IDLE: begin
        if (memop) begin
          req           = 1'b1;
          stall         = 1'b1;
          state_d       = BUSY;
          cnt_d         = '0;
          wb_regwrite_d = 1'b0;
          wb_memtoreg_d = 1'b0;
        end else begin
          wb_regwrite_d = in_RegWrite;
          wb_memtoreg_d = in_MemtoReg;
          wb_alu_out_d  = in_alu_out;
          wb_rdata_d    = '0;
          wb_pc_d       = inpc;
          wb_mux_d      = in_mux;
        end
      end
      BUSY: begin
        req   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Ack is checked before the watchdog so a same-cycle ack always wins.
        if (mem_ack) begin
          state_d       = IDLE;
          wb_regwrite_d = in_RegWrite;
          wb_memtoreg_d = in_MemtoReg;
          wb_alu_out_d  = in_alu_out;
          wb_rdata_d    = in_MemRead ? mem_rdata : 32'd0;
          wb_pc_d       = inpc;
          wb_mux_d      = in_mux;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          mem_err_d     = 1'b1;
          wb_regwrite_d = 1'b0;
          wb_memtoreg_d = 1'b0;
        end else begin
          stall         = 1'b1;
          wb_regwrite_d = 1'b0;
          wb_memtoreg_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_err_q     <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_alu_out_q  <= '0;
      wb_rdata_q    <= '0;
      wb_pc_q       <= '0;
      wb_mux_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_err_q     <= mem_err_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_alu_out_q  <= wb_alu_out_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_pc_q       <= wb_pc_d;
      wb_mux_q      <= wb_mux_d;
    end
  end

  assign mem_err     = mem_err_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_MemtoReg = wb_memtoreg_q;
  assign wb_alu_out  = wb_alu_out_q;
  assign wb_rdata    = wb_rdata_q;
  assign wb_pc       = wb_pc_q;
  assign wb_mux      = wb_mux_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Self-checking bench for mem_wb_stage (directed + random ops).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        in_RegWrite, in_Branch, in_MemtoReg, in_MemRead, in_MemWrite, in_Jump;
  logic [5:0]  in_opcode;
  logic        in_zero;
  logic [4:0]  in_mux;
  logic [31:0] in_pc, inpc, in_alu_out, in_rd2, in_jump_addr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, redirect;
  logic [31:0] next_pc;
  logic        mem_err;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [31:0] wb_alu_out, wb_rdata, wb_pc;
  logic [4:0]  wb_mux;

  int checks = 0;
  int errors = 0;

  // Reference view of the MEM/WB register and the error flag.
  logic        m_rw, m_mt, m_err;
  logic [31:0] m_alu, m_rdata, m_pc;
  logic [4:0]  m_mux;

  mem_wb_stage #(.TIMEOUT(TMO), .CNT_W(5), .OP_BNE(6'h05)) dut (
    .clk(clk), .rst(rst),
    .in_RegWrite(in_RegWrite), .in_Branch(in_Branch), .in_MemtoReg(in_MemtoReg),
    .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_Jump(in_Jump),
    .in_opcode(in_opcode), .in_zero(in_zero), .in_mux(in_mux),
    .in_pc(in_pc), .inpc(inpc), .in_alu_out(in_alu_out), .in_rd2(in_rd2),
    .in_jump_addr(in_jump_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .redirect(redirect), .next_pc(next_pc), .mem_err(mem_err),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_alu_out(wb_alu_out), .wb_rdata(wb_rdata), .wb_pc(wb_pc), .wb_mux(wb_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 32'(m_rw));
    chk({tag, ".wb_MemtoReg"}, 32'(wb_MemtoReg), 32'(m_mt));
    chk({tag, ".wb_alu_out"}, wb_alu_out, m_alu);
    chk({tag, ".wb_rdata"}, wb_rdata, m_rdata);
    chk({tag, ".wb_pc"}, wb_pc, m_pc);
    chk({tag, ".wb_mux"}, 32'(wb_mux), 32'(m_mux));
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_rw = 0; m_mt = 0; m_err = 0;
    m_alu = 0; m_rdata = 0; m_pc = 0; m_mux = 0;
  endtask

  // Runs one instruction starting just after a rising edge.
  // lat: cycle (after the request cycle) on which ack arrives; <0 means never.
  task automatic do_op(input string tag,
                       input bit rw, input bit mt, input bit mr, input bit mw,
                       input bit br, input bit jp, input logic [5:0] op, input bit z,
                       input logic [4:0] mux, input logic [31:0] pc, input logic [31:0] link,
                       input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [31:0] jaddr, input logic [31:0] rdata, input int lat);
    bit memop;
    bit exp_redir;
    int done;
    int req_cycles;
    int stall_cycles;
    in_RegWrite = rw; in_MemtoReg = mt; in_MemRead = mr; in_MemWrite = mw;
    in_Branch = br; in_Jump = jp; in_opcode = op; in_zero = z;
    in_mux = mux; in_pc = pc; inpc = link; in_alu_out = alu; in_rd2 = rd2;
    in_jump_addr = jaddr; mem_rdata = rdata;
    memop = mr | mw;
    exp_redir = jp | (br & ((op == 6'h05) ? !z : z));
    if (!memop)                   done = 0;
    else if (lat < 0 || lat > TMO) done = TMO;
    else                           done = lat;
    req_cycles = 0;
    stall_cycles = 0;
    for (int k = 0; k <= TMO; k++) begin
      mem_ack = (memop && k == lat) ? 1'b1 : 1'b0;
      @(negedge clk);
      req_cycles   += int'(mem_req);
      stall_cycles += int'(stall);
      if (k == 0) begin
        chk({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
        chk({tag, ".next_pc"}, next_pc, jp ? jaddr : pc);
        if (memop) begin
          chk({tag, ".mem_we"}, 32'(mem_we), 32'(mw));
          chk({tag, ".mem_addr"}, mem_addr, alu);
          chk({tag, ".mem_wdata"}, mem_wdata, rd2);
        end
      end
      if (k == 1) chk({tag, ".bubble_rw"}, 32'(wb_RegWrite), 32'd0);
      @(posedge clk);
      #1;
      if (k == done) break;
    end
    mem_ack = 1'b0;
    chk({tag, ".req_cycles"}, 32'(req_cycles), memop ? 32'(done + 1) : 32'd0);
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(done));
    if (memop && (lat < 0 || lat > TMO)) begin
      m_rw = 0; m_mt = 0; m_err = 1;
    end else begin
      m_rw = rw; m_mt = mt; m_alu = alu; m_pc = link; m_mux = mux;
      m_rdata = mr ? rdata : 32'd0;
    end
    chk_wb(tag);
  endtask

  initial begin
    int kind, lat;
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 0;
    in_RegWrite = 0; in_Branch = 0; in_MemtoReg = 0; in_MemRead = 0; in_MemWrite = 0;
    in_Jump = 0; in_opcode = 0; in_zero = 0; in_mux = 0; in_pc = 0; inpc = 0;
    in_alu_out = 0; in_rd2 = 0; in_jump_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_wb("reset");
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_op("alu", 1, 0, 0, 0, 0, 0, 6'h00, 0, 5'd5, 32'h100, 32'h104, 32'h1234, 0, 0, 0, 0);
    do_op("load", 1, 1, 1, 0, 0, 0, 6'h23, 0, 5'd7, 32'h200, 32'h204, 32'h40, 0, 0,
          32'hDEADBEEF, 3);
    do_op("store", 0, 0, 0, 1, 0, 0, 6'h2B, 0, 5'd0, 32'h300, 32'h304, 32'h80,
          32'hA5A5A5A5, 0, 32'h11111111, 1);
    do_op("beq", 0, 0, 0, 0, 1, 0, 6'h04, 1, 5'd0, 32'h400, 32'h404, 0, 0, 32'h999, 0, 0);
    do_op("bne_z1", 0, 0, 0, 0, 1, 0, 6'h05, 1, 5'd0, 32'h500, 32'h504, 0, 0, 32'h999, 0, 0);
    do_op("jmp_br", 1, 0, 0, 0, 1, 1, 6'h04, 1, 5'd31, 32'h600, 32'h604, 0, 0,
          32'hABC0, 0, 0);
    do_op("timeout", 1, 1, 1, 0, 0, 0, 6'h23, 0, 5'd9, 32'h700, 32'h704, 32'h44, 0, 0,
          32'h5555, -1);
    do_op("ack_at_tmo", 1, 1, 1, 0, 0, 0, 6'h23, 0, 5'd10, 32'h710, 32'h714, 32'h48, 0, 0,
          32'h6666, TMO);
    do_op("post_tmo", 1, 0, 0, 0, 0, 0, 6'h00, 0, 5'd3, 32'h800, 32'h804, 32'h77, 0, 0, 0, 0);

    // Reset in the middle of an outstanding load, then a late ack.
    in_RegWrite = 1; in_MemtoReg = 1; in_MemRead = 1; in_MemWrite = 0;
    in_Branch = 0; in_Jump = 0; in_alu_out = 32'hC0; in_mux = 5'd4;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rstmid.mem_req", 32'(mem_req), 32'd0);
    chk_wb("rstmid");
    in_MemRead = 0; in_RegWrite = 0; in_MemtoReg = 0;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("rstrel.stall", 32'(stall), 32'd0);
    chk("rstrel.mem_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    m_pc = inpc; m_alu = in_alu_out; m_mux = in_mux;
    chk_wb("rstrel");

    // Random mix of ALU, load, store, branch and jump traffic.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      lat  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 5));
      do_op($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), kind == 1, kind == 2,
            1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0) ? 6'h05 : 6'($urandom), 1'($urandom),
            5'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
